// File: rtl/pixel_pkg.sv
// Shared constants and types for the dino-game VGA pixel path.
package pixel_pkg;

  localparam int CH_W      = 4;
  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = 5;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb12;

endpackage

// File: rtl/pixel_compositor_fade_level_ctrl.sv
// Frame-synchronous day/night fade level plus optional game-over flash phase.
// Flash logic exists only when PIXEL_COMPOSITOR_FLASH_EN is defined.
module fade_level_ctrl
  import pixel_pkg::*;
#(
  parameter int FADE_STEP    = 1,
  parameter int FLASH_FRAMES = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               night_req,
  input  logic               game_over,
  output logic [LEVEL_W-1:0] level,
  output logic               fade_busy,
  output logic               flash_phase
);

  localparam logic [LEVEL_W:0] STEP = (LEVEL_W + 1)'(FADE_STEP);
  localparam logic [LEVEL_W:0] MAX  = (LEVEL_W + 1)'(LEVEL_MAX);

  logic [LEVEL_W-1:0] r_level;
  logic               r_fade_busy;
  logic [LEVEL_W-1:0] w_target;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic [LEVEL_W:0]   w_up;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_target    = night_req ? LEVEL_W'(LEVEL_MAX) : '0;
    w_up        = {1'b0, r_level} + STEP;
    w_level_nxt = r_level;
    if (frame_tick) begin
      if (r_level < w_target)
        w_level_nxt = (w_up >= MAX) ? w_target : w_up[LEVEL_W-1:0];
      else if (r_level > w_target)
        w_level_nxt = ({1'b0, r_level} > STEP) ? r_level - STEP[LEVEL_W-1:0] : w_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level     <= '0;
      r_fade_busy <= 1'b0;
    end else begin
      r_level     <= w_level_nxt;
      r_fade_busy <= (w_level_nxt != w_target);
    end
  end

  assign level     = r_level;
  assign fade_busy = r_fade_busy;

`ifdef PIXEL_COMPOSITOR_FLASH_EN
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);

  logic [7:0] r_flash_cnt;
  logic       r_flash_phase;

  always_ff @(posedge clk) begin
    if (rst || !game_over) begin
      r_flash_cnt   <= '0;
      r_flash_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_flash_cnt == FLASH_LAST) begin
        r_flash_cnt   <= '0;
        r_flash_phase <= ~r_flash_phase;
      end else begin
        r_flash_cnt <= r_flash_cnt + 8'd1;
      end
    end
  end

  assign flash_phase = r_flash_phase;
`else
  logic w_unused;
  assign w_unused    = game_over ^ (FLASH_FRAMES == 0);
  assign flash_phase = 1'b0;
`endif

endmodule

// File: rtl/pixel_compositor.sv
// Priority layer compositor with day/night blend and 2-stage registered RGB output.
// Optional game-over flash is enabled by defining PIXEL_COMPOSITOR_FLASH_EN.
module pixel_compositor
  import pixel_pkg::*;
#(
  parameter int                    N_LAYERS     = 3,
  parameter logic [4*N_LAYERS-1:0] LAYER_SHADE  = '0,
  parameter logic [CH_W-1:0]       BG_SHADE     = 4'hF,
  parameter int                    FADE_STEP    = 1,
  parameter int                    FLASH_FRAMES = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [N_LAYERS-1:0] layer_hit,
  input  logic                frame_tick,
  input  logic                night_req,
  input  logic                game_over,
  output logic [CH_W-1:0]     vgaRed,
  output logic [CH_W-1:0]     vgaGreen,
  output logic [CH_W-1:0]     vgaBlue,
  output logic                fade_busy
);

  logic [LEVEL_W-1:0] w_level;
  logic               w_flash;

  fade_level_ctrl #(
    .FADE_STEP    (FADE_STEP),
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_fade (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .night_req   (night_req),
    .game_over   (game_over),
    .level       (w_level),
    .fade_busy   (fade_busy),
    .flash_phase (w_flash)
  );

  logic [CH_W-1:0] w_d;
  logic [CH_W-1:0] r_d;
  logic            r_v1;

  // Scan from the lowest priority up so the lowest-index hit lands last.
  always_comb begin
    w_d = BG_SHADE;
    for (int k = N_LAYERS - 1; k >= 0; k--)
      if (layer_hit[k]) w_d = LAYER_SHADE[4*k +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d  <= '0;
    end else begin
      r_v1 <= valid;
      r_d  <= w_d;
    end
  end

  logic signed [5:0]  w_t;
  logic signed [10:0] w_p;
  logic signed [10:0] w_s;
  logic [CH_W-1:0]    w_clamp;
  logic [CH_W-1:0]    w_pix;
  rgb12               r_rgb;

  // Blend d toward 15-d: s = d + ((15 - 2d) * level) / 16, floor-rounded.
  assign w_t = 6'sd15 - $signed({1'b0, r_d, 1'b0});
  assign w_p = 11'(w_t) * 11'($signed({1'b0, w_level}));
  assign w_s = $signed({7'b0, r_d}) + (w_p >>> 4);

  always_comb begin
    if (w_s < 11'sd0)       w_clamp = '0;
    else if (w_s > 11'sd15) w_clamp = 4'hF;
    else                    w_clamp = w_s[CH_W-1:0];
    if (!r_v1)              w_pix   = '0;
    else if (w_flash)       w_pix   = ~w_clamp;
    else                    w_pix   = w_clamp;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rgb <= '0;
    else     r_rgb <= '{r: w_pix, g: w_pix, b: w_pix};
  end

  assign vgaRed   = r_rgb.r;
  assign vgaGreen = r_rgb.g;
  assign vgaBlue  = r_rgb.b;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench: default instance A and instance B (shades 8/4/0, step 4, flash period 2).
module tb_pixel_compositor;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [2:0] layer_hit;
  logic       frame_tick;
  logic       night_req;
  logic       game_over;

  logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic       busy_a, busy_b;
  logic [11:0] rgb_a, rgb_b;

  int n_cmp = 0;
  int n_err = 0;

  always #20 clk = ~clk;

  assign rgb_a = {red_a, green_a, blue_a};
  assign rgb_b = {red_b, green_b, blue_b};

  pixel_compositor u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .layer_hit  (layer_hit),
    .frame_tick (frame_tick),
    .night_req  (night_req),
    .game_over  (game_over),
    .vgaRed     (red_a),
    .vgaGreen   (green_a),
    .vgaBlue    (blue_a),
    .fade_busy  (busy_a)
  );

  pixel_compositor #(
    .LAYER_SHADE  (12'h840),
    .FADE_STEP    (4),
    .FLASH_FRAMES (2)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .layer_hit  (layer_hit),
    .frame_tick (frame_tick),
    .night_req  (night_req),
    .game_over  (game_over),
    .vgaRed     (red_b),
    .vgaGreen   (green_b),
    .vgaBlue    (blue_b),
    .fade_busy  (busy_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pixel(input logic v, input logic [2:0] h);
    valid     = v;
    layer_hit = h;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    valid      = 1'b1;
    layer_hit  = 3'b111;
    frame_tick = 1'b0;
    night_req  = 1'b0;
    game_over  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb_a",   16'(rgb_a), 16'h000);
    check("rst_rgb_b",   16'(rgb_b), 16'h000);
    check("rst_busy_b",  16'(busy_b), 16'h0);
    check("rst_level_b", 16'(u_dut_b.w_level), 16'd0);

    rst = 1'b0;
    pixel(1'b1, 3'b000);
    check("bg_day_a", 16'(rgb_a), 16'hFFF);
    check("bg_day_b", 16'(rgb_b), 16'hFFF);

    layer_hit = 3'b010;
    @(negedge clk);
    check("latency_1clk_a", 16'(rgb_a), 16'hFFF);
    @(negedge clk);
    check("latency_2clk_a", 16'(rgb_a), 16'h000);
    check("hit010_b",       16'(rgb_b), 16'h444);

    pixel(1'b1, 3'b110);
    check("hit110_b", 16'(rgb_b), 16'h444);
    pixel(1'b1, 3'b111);
    check("hit111_b", 16'(rgb_b), 16'h000);
    pixel(1'b1, 3'b100);
    check("hit100_b", 16'(rgb_b), 16'h888);
    pixel(1'b0, 3'b111);
    check("invalid_a", 16'(rgb_a), 16'h000);
    check("invalid_b", 16'(rgb_b), 16'h000);
    pixel(1'b1, 3'b000);
    check("bg_again_b", 16'(rgb_b), 16'hFFF);

    night_req = 1'b1;
    @(negedge clk);
    check("night_busy_b",   16'(busy_b), 16'h1);
    check("night_notick_b", 16'(u_dut_b.w_level), 16'd0);
    tick();
    check("fade1_level_b", 16'(u_dut_b.w_level), 16'd4);
    check("fade1_busy_b",  16'(busy_b), 16'h1);
    tick();
    check("fade2_level_b", 16'(u_dut_b.w_level), 16'd8);
    check("fade2_rgb_b",   16'(rgb_b), 16'h777);
    tick();
    check("fade3_level_b", 16'(u_dut_b.w_level), 16'd12);
    check("fade3_busy_b",  16'(busy_b), 16'h1);
    tick();
    check("fade4_level_b", 16'(u_dut_b.w_level), 16'd16);
    check("fade4_busy_b",  16'(busy_b), 16'h0);
    check("fade4_rgb_b",   16'(rgb_b), 16'h000);
    tick();
    check("fade5_level_b", 16'(u_dut_b.w_level), 16'd16);
    check("fade5_level_a", 16'(u_dut_a.w_level), 16'd5);
    check("fade5_rgb_a",   16'(rgb_a), 16'hAAA);
    check("fade5_busy_a",  16'(busy_a), 16'h1);

    night_req = 1'b0;
    @(negedge clk);
    check("day_notick_b", 16'(u_dut_b.w_level), 16'd16);
    check("day_busy_b",   16'(busy_b), 16'h1);
    tick();
    check("unfade1_level_b", 16'(u_dut_b.w_level), 16'd12);
    tick();
    check("unfade2_level_b", 16'(u_dut_b.w_level), 16'd8);
    check("unfade2_rgb_b",   16'(rgb_b), 16'h777);
    tick();
    check("unfade3_level_b", 16'(u_dut_b.w_level), 16'd4);
    tick();
    check("unfade4_level_b", 16'(u_dut_b.w_level), 16'd0);
    check("unfade4_busy_b",  16'(busy_b), 16'h0);
    check("unfade4_rgb_b",   16'(rgb_b), 16'hFFF);

    night_req = 1'b1;
    tick();
    check("midfade_level_b", 16'(u_dut_b.w_level), 16'd4);
    rst        = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    check("rst_tick_level_b", 16'(u_dut_b.w_level), 16'd0);
    check("rst_tick_busy_b",  16'(busy_b), 16'h0);
    check("rst_tick_rgb_b",   16'(rgb_b), 16'h000);
    rst        = 1'b0;
    frame_tick = 1'b0;
    night_req  = 1'b0;

    pixel(1'b1, 3'b000);
    check("post_rst_rgb_b", 16'(rgb_b), 16'hFFF);
    game_over = 1'b1;
`ifdef PIXEL_COMPOSITOR_FLASH_EN
    tick();
    check("flash_t1_b", 16'(rgb_b), 16'hFFF);
    tick();
    check("flash_t2_b", 16'(rgb_b), 16'h000);
    tick();
    check("flash_t3_b", 16'(rgb_b), 16'h000);
    tick();
    check("flash_t4_b", 16'(rgb_b), 16'hFFF);
    tick();
    tick();
    check("flash_t6_b", 16'(rgb_b), 16'h000);
    check("flash_t6_a", 16'(rgb_a), 16'hFFF);
    game_over = 1'b0;
    repeat (2) @(negedge clk);
    check("flash_off_b", 16'(rgb_b), 16'hFFF);
`else
    tick();
    tick();
    check("noflash_t2_b", 16'(rgb_b), 16'hFFF);
    tick();
    tick();
    check("noflash_t4_b", 16'(rgb_b), 16'hFFF);
    game_over = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
